// File: rtl/seg_cathode_driver.sv
// Cathode driver for a 4-digit multiplexed 7-segment display: synchronises the
// anode select, latches the value once per frame and blanks around digit changes.
module seg_cathode_driver #(
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  anode,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank_en,
    output logic [7:0]  cathode,
    output logic        frame_start,
    output logic        anode_err
);

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  a_s_q, a_s_d;
    logic [7:0]  a_prev_q, a_prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] shadow_val_q, shadow_val_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [1:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic [7:0]  cathode_q, cathode_d;
    logic        frame_start_q, frame_start_d;
    logic        anode_err_q, anode_err_d;

    logic        change;
    logic        legal;
    logic [1:0]  idx;
    logic [3:0]  nibble;
    logic [6:0]  seg_raw;
    logic [7:0]  seg;
    logic [3:0]  lz_mask;

    // Digit k is a leading zero when every nibble from 3 down to k is zero.
    assign lz_mask[0] = 1'b0;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
        assign lz_mask[gi] = ~|shadow_val_q[15:4*gi];
    end

    always_comb begin
        change = (a_s_q != a_prev_q);
        legal  = 1'b1;
        idx    = 2'd0;
        case (a_s_q)
            8'hFE:   idx = 2'd0;
            8'hFD:   idx = 2'd1;
            8'hFB:   idx = 2'd2;
            8'hF7:   idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        nibble  = shadow_val_q[{sel_q, 2'b00} +: 4];
        seg_raw = 7'h7F;
        case (nibble)
            4'h0: seg_raw = 7'h40;
            4'h1: seg_raw = 7'h79;
            4'h2: seg_raw = 7'h24;
            4'h3: seg_raw = 7'h30;
            4'h4: seg_raw = 7'h19;
            4'h5: seg_raw = 7'h12;
            4'h6: seg_raw = 7'h02;
            4'h7: seg_raw = 7'h78;
            4'h8: seg_raw = 7'h00;
            4'h9: seg_raw = 7'h10;
            4'hA: seg_raw = 7'h08;
            4'hB: seg_raw = 7'h03;
            4'hC: seg_raw = 7'h46;
            4'hD: seg_raw = 7'h21;
            4'hE: seg_raw = 7'h06;
            4'hF: seg_raw = 7'h0E;
            default: seg_raw = 7'h7F;
        endcase
        if (lz_blank_en && lz_mask[sel_q]) begin
            seg_raw = 7'h7F;
        end
        seg = {~shadow_dp_q[sel_q], seg_raw};
    end

    always_comb begin
        sync1_d       = anode;
        a_s_d         = sync1_q;
        a_prev_d      = a_s_q;
        cnt_d         = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        sel_d         = sel_q;
        valid_d       = valid_q;
        frame_start_d = 1'b0;
        anode_err_d   = anode_err_q | (!legal && (a_s_q != 8'hFF));

        if (change) begin
            if (legal) begin
                cnt_d   = BLANK_LOAD;
                sel_d   = idx;
                valid_d = 1'b1;
                if (idx == 2'd0) begin
                    shadow_val_d  = value;
                    shadow_dp_d   = dp_in;
                    frame_start_d = 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end

        // Segment lookup uses the settled selection; any change forces blank first.
        cathode_d = (cnt_d != 8'd0 || !valid_d) ? 8'hFF : seg;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q       <= 8'hFF;
            a_s_q         <= 8'hFF;
            a_prev_q      <= 8'hFF;
            cnt_q         <= 8'd0;
            shadow_val_q  <= 16'd0;
            shadow_dp_q   <= 4'd0;
            sel_q         <= 2'd0;
            valid_q       <= 1'b0;
            cathode_q     <= 8'hFF;
            frame_start_q <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            a_s_q         <= a_s_d;
            a_prev_q      <= a_prev_d;
            cnt_q         <= cnt_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            sel_q         <= sel_d;
            valid_q       <= valid_d;
            cathode_q     <= cathode_d;
            frame_start_q <= frame_start_d;
            anode_err_q   <= anode_err_d;
        end
    end

    assign cathode     = cathode_q;
    assign frame_start = frame_start_q;
    assign anode_err   = anode_err_q;

endmodule
